// File: rtl/usrp2_tx_fifo_arbiter_if.sv
// Handshake bundle between the two TX sample sources, the arbiter and the
// width-converter FIFO enqueue port. The arbiter side uses the slave modport.
interface usrp2_tx_fifo_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] req0_dat_i;
  logic              req0_en_i;
  logic              req0_last_i;
  logic              req0_rdy_o;
  logic [DATA_W-1:0] req1_dat_i;
  logic              req1_en_i;
  logic              req1_last_i;
  logic              req1_rdy_o;
  logic [DATA_W-1:0] fifo_dat_o;
  logic              fifo_enq_en_o;
  logic              fifo_enq_rdy_i;
  logic [1:0]        grant_o;
  logic              burst_trunc_o;

  modport slave (
    input  req0_dat_i, req0_en_i, req0_last_i,
    input  req1_dat_i, req1_en_i, req1_last_i,
    input  fifo_enq_rdy_i,
    output req0_rdy_o, req1_rdy_o,
    output fifo_dat_o, fifo_enq_en_o,
    output grant_o, burst_trunc_o
  );

  modport master (
    output req0_dat_i, req0_en_i, req0_last_i,
    output req1_dat_i, req1_en_i, req1_last_i,
    output fifo_enq_rdy_i,
    input  req0_rdy_o, req1_rdy_o,
    input  fifo_dat_o, fifo_enq_en_o,
    input  grant_o, burst_trunc_o
  );
endinterface

// File: rtl/usrp2_tx_fifo_arbiter.sv
// Burst-granular round-robin arbiter sharing the USRP2 TX FIFO enqueue port
// between the baseband path (req0) and the preamble/control injector (req1).
module usrp2_tx_fifo_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 9
) (
  input logic                    dsp_clk,
  input logic                    dsp_rst,
  usrp2_tx_fifo_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              trunc_q, trunc_d;

  logic [DATA_W-1:0] dat_mux;
  logic              rdy0, rdy1;
  logic              sel_en, sel_last;
  logic              enq_en;
  logic [CNT_W-1:0]  beat_inc;
  logic [1:0]        grant;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    dat_mux    = '0;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    sel_en     = 1'b0;
    sel_last   = 1'b0;
    grant      = 2'b00;

    case (state_q)
      G0: begin
        grant    = 2'b01;
        rdy0     = bus.fifo_enq_rdy_i;
        sel_en   = bus.req0_en_i;
        sel_last = bus.req0_last_i;
        dat_mux  = bus.req0_dat_i;
      end
      G1: begin
        grant    = 2'b10;
        rdy1     = bus.fifo_enq_rdy_i;
        sel_en   = bus.req1_en_i;
        sel_last = bus.req1_last_i;
        dat_mux  = bus.req1_dat_i;
      end
      default: begin
        // No beat moves while idle; a tie goes to whichever source prio names.
        if (bus.req0_en_i && bus.req1_en_i) begin
          state_d = prio_q ? G1 : G0;
        end else if (bus.req0_en_i) begin
          state_d = G0;
        end else if (bus.req1_en_i) begin
          state_d = G1;
        end
      end
    endcase

    enq_en   = sel_en && bus.fifo_enq_rdy_i;
    beat_inc = beat_cnt_q + CNT_W'(1);

    // A burst ends on its last beat or on the beat cap; only a cap without
    // last flags truncation, and the other source becomes favoured either way.
    if (enq_en) begin
      beat_cnt_d = beat_inc;
      if (sel_last || (beat_inc == CNT_W'(MAX_BURST))) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        prio_d     = (state_q == G0);
        trunc_d    = !sel_last;
      end
    end
  end

  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign bus.req0_rdy_o    = rdy0;
  assign bus.req1_rdy_o    = rdy1;
  assign bus.fifo_dat_o    = dat_mux;
  assign bus.fifo_enq_en_o = enq_en;
  assign bus.grant_o       = grant;
  assign bus.burst_trunc_o = trunc_q;

endmodule

// File: tb/tb_usrp2_tx_fifo_arbiter.sv
// Bench for usrp2_tx_fifo_arbiter: three instances (caps 256, 4, 3) share one
// stimulus stream and are each compared every cycle against a burst-level model.
module tb_usrp2_tx_fifo_arbiter;

  localparam int DW = 32;
  localparam int NI = 3;
  localparam int CAP [NI] = '{256, 4, 3};

  typedef struct {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  logic          dsp_clk = 1'b0;
  logic          dsp_rst = 1'b1;
  logic [DW-1:0] req0_dat = '0;
  logic [DW-1:0] req1_dat = '0;
  logic          req0_en = 1'b0, req0_last = 1'b0;
  logic          req1_en = 1'b0, req1_last = 1'b0;
  logic          fifo_rdy = 1'b0;

  always #5 dsp_clk = ~dsp_clk;

  usrp2_tx_fifo_arbiter_if #(.DATA_W(DW)) bus0 ();
  usrp2_tx_fifo_arbiter_if #(.DATA_W(DW)) bus1 ();
  usrp2_tx_fifo_arbiter_if #(.DATA_W(DW)) bus2 ();

  assign bus0.req0_dat_i = req0_dat;  assign bus0.req0_en_i = req0_en;  assign bus0.req0_last_i = req0_last;
  assign bus0.req1_dat_i = req1_dat;  assign bus0.req1_en_i = req1_en;  assign bus0.req1_last_i = req1_last;
  assign bus0.fifo_enq_rdy_i = fifo_rdy;
  assign bus1.req0_dat_i = req0_dat;  assign bus1.req0_en_i = req0_en;  assign bus1.req0_last_i = req0_last;
  assign bus1.req1_dat_i = req1_dat;  assign bus1.req1_en_i = req1_en;  assign bus1.req1_last_i = req1_last;
  assign bus1.fifo_enq_rdy_i = fifo_rdy;
  assign bus2.req0_dat_i = req0_dat;  assign bus2.req0_en_i = req0_en;  assign bus2.req0_last_i = req0_last;
  assign bus2.req1_dat_i = req1_dat;  assign bus2.req1_en_i = req1_en;  assign bus2.req1_last_i = req1_last;
  assign bus2.fifo_enq_rdy_i = fifo_rdy;

  usrp2_tx_fifo_arbiter #(.DATA_W(DW), .MAX_BURST(256), .CNT_W(9)) dut0 (
    .dsp_clk(dsp_clk), .dsp_rst(dsp_rst), .bus(bus0));
  usrp2_tx_fifo_arbiter #(.DATA_W(DW), .MAX_BURST(4), .CNT_W(3)) dut1 (
    .dsp_clk(dsp_clk), .dsp_rst(dsp_rst), .bus(bus1));
  usrp2_tx_fifo_arbiter #(.DATA_W(DW), .MAX_BURST(3), .CNT_W(2)) dut2 (
    .dsp_clk(dsp_clk), .dsp_rst(dsp_rst), .bus(bus2));

  // Model per instance: owner -1 means nobody holds the port.
  int   owner   [NI];
  int   taken   [NI];
  int   favored [NI];
  logic trunc_nxt [NI];
  int   enq_cnt   [NI];
  int   trunc_cnt [NI];

  beat_t q0[$];
  beat_t q1[$];
  int    act;
  int    tests = 0;
  int    fails = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample_inst(input int k, output logic [1:0] g, output logic r0, output logic r1,
                             output logic en, output logic tr, output logic [DW-1:0] d);
    case (k)
      0: begin g = bus0.grant_o; r0 = bus0.req0_rdy_o; r1 = bus0.req1_rdy_o;
               en = bus0.fifo_enq_en_o; tr = bus0.burst_trunc_o; d = bus0.fifo_dat_o; end
      1: begin g = bus1.grant_o; r0 = bus1.req0_rdy_o; r1 = bus1.req1_rdy_o;
               en = bus1.fifo_enq_en_o; tr = bus1.burst_trunc_o; d = bus1.fifo_dat_o; end
      default: begin g = bus2.grant_o; r0 = bus2.req0_rdy_o; r1 = bus2.req1_rdy_o;
               en = bus2.fifo_enq_en_o; tr = bus2.burst_trunc_o; d = bus2.fifo_dat_o; end
    endcase
  endtask

  function automatic logic src_en(input int s);
    return (s == 0) ? req0_en : req1_en;
  endfunction

  function automatic logic src_last(input int s);
    return (s == 0) ? req0_last : req1_last;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      owner[k] = -1; taken[k] = 0; favored[k] = 0; trunc_nxt[k] = 1'b0;
    end
  endtask

  // Advance every model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      logic nt;
      nt = 1'b0;
      if (owner[k] < 0) begin
        if (req0_en && req1_en) owner[k] = favored[k];
        else if (req0_en)       owner[k] = 0;
        else if (req1_en)       owner[k] = 1;
      end else if (src_en(owner[k]) && fifo_rdy) begin
        taken[k]++;
        if (src_last(owner[k]) || taken[k] >= CAP[k]) begin
          nt         = !src_last(owner[k]);
          favored[k] = 1 - owner[k];
          owner[k]   = -1;
          taken[k]   = 0;
        end
      end
      trunc_nxt[k] = nt;
    end
  endtask

  task automatic checkOutput();
    logic [1:0] g;
    logic r0, r1, en, tr;
    logic [DW-1:0] d;
    logic [1:0] eg;
    logic [DW-1:0] ed;
    for (int k = 0; k < NI; k++) begin
      sample_inst(k, g, r0, r1, en, tr, d);
      eg = (owner[k] == 0) ? 2'b01 : (owner[k] == 1) ? 2'b10 : 2'b00;
      ed = (owner[k] == 0) ? req0_dat : (owner[k] == 1) ? req1_dat : '0;
      check_eq($sformatf("inst%0d grant", k), DW'(g), DW'(eg));
      check_eq($sformatf("inst%0d req0_rdy", k), DW'(r0), DW'(owner[k] == 0 && fifo_rdy));
      check_eq($sformatf("inst%0d req1_rdy", k), DW'(r1), DW'(owner[k] == 1 && fifo_rdy));
      check_eq($sformatf("inst%0d enq_en", k), DW'(en),
               DW'(owner[k] >= 0 && src_en(owner[k]) && fifo_rdy));
      check_eq($sformatf("inst%0d fifo_dat", k), d, ed);
      check_eq($sformatf("inst%0d trunc", k), DW'(tr), DW'(trunc_nxt[k]));
      if (en === 1'b1) enq_cnt[k]++;
      if (tr === 1'b1) trunc_cnt[k]++;
    end
  endtask

  task automatic drive_inputs(input int en_pct, input int rdy_pct);
    req0_en   = (q0.size() > 0) && (int'($urandom_range(99)) < en_pct);
    req0_dat  = (q0.size() > 0) ? q0[0].dat : '0;
    req0_last = (q0.size() > 0) ? q0[0].last : 1'b0;
    req1_en   = (q1.size() > 0) && (int'($urandom_range(99)) < en_pct);
    req1_dat  = (q1.size() > 0) ? q1[0].dat : '0;
    req1_last = (q1.size() > 0) ? q1[0].last : 1'b0;
    fifo_rdy  = int'($urandom_range(99)) < rdy_pct;
  endtask

  // One full cycle: apply, check, step the model, cross the edge, retire beats.
  task automatic applyStimulus(input int en_pct, input int rdy_pct);
    logic acc0, acc1;
    drive_inputs(en_pct, rdy_pct);
    #1;
    checkOutput();
    acc0 = req0_en && owner[act] == 0 && fifo_rdy;
    acc1 = req1_en && owner[act] == 1 && fifo_rdy;
    model_step();
    @(posedge dsp_clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
  endtask

  task automatic load_burst(input int src, input int n);
    beat_t b;
    for (int i = 1; i <= n; i++) begin
      b.dat  = $urandom;
      b.last = (i == n);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic clear_inputs();
    q0.delete(); q1.delete();
    req0_en = 1'b0; req1_en = 1'b0; req0_last = 1'b0; req1_last = 1'b0;
    req0_dat = '0; req1_dat = '0; fifo_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge dsp_clk);
    clear_inputs();
    dsp_rst = 1'b1;
    #1;
    model_reset();
    checkOutput();
    repeat (2) @(posedge dsp_clk);
    #3 dsp_rst = 1'b0;
    @(posedge dsp_clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      enq_cnt[k] = 0; trunc_cnt[k] = 0;
    end
  endtask

  task automatic run_drain(input int en_pct, input int rdy_pct, input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin
      applyStimulus(en_pct, rdy_pct);
      n++;
    end
    tests++;
    assert (n < max_cyc) else begin
      fails++;
      $error("[TB] FAIL drain_timeout: observed %0d cycles, limit %0d", n, max_cyc);
    end
    repeat (2) applyStimulus(100, 100);
  endtask

  initial begin
    int total;
    act = 0;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      enq_cnt[k] = 0; trunc_cnt[k] = 0;
    end

    $display("[TB] single req0 burst of 4");
    do_reset();
    act = 0;
    load_burst(0, 4);
    run_drain(100, 100, 40);
    check_eq("s1 enq count", DW'(enq_cnt[0]), DW'(4));
    check_eq("s1 trunc count", DW'(trunc_cnt[0]), DW'(0));

    $display("[TB] alternating 2-beat bursts");
    do_reset();
    act = 0;
    load_burst(0, 2); load_burst(0, 2);
    load_burst(1, 2); load_burst(1, 2);
    run_drain(100, 100, 60);
    check_eq("s2 enq count", DW'(enq_cnt[0]), DW'(8));

    $display("[TB] FIFO backpressure mid req1 burst");
    do_reset();
    act = 0;
    load_burst(1, 6);
    repeat (3) applyStimulus(100, 100);
    repeat (3) applyStimulus(100, 0);
    run_drain(100, 100, 40);
    check_eq("s3 enq count", DW'(enq_cnt[0]), DW'(6));

    $display("[TB] cap 4 truncation of 6-beat burst");
    do_reset();
    act = 1;
    load_burst(0, 6);
    run_drain(100, 100, 40);
    check_eq("s4 enq count", DW'(enq_cnt[1]), DW'(6));
    check_eq("s4 trunc count", DW'(trunc_cnt[1]), DW'(1));

    $display("[TB] async reset mid req1 burst");
    do_reset();
    act = 0;
    load_burst(1, 5);
    repeat (2) applyStimulus(100, 100);
    drive_inputs(100, 100);
    #1;
    checkOutput();
    #2 dsp_rst = 1'b1;
    #1;
    model_reset();
    checkOutput();
    clear_inputs();
    @(posedge dsp_clk);
    #4 dsp_rst = 1'b0;
    @(posedge dsp_clk);
    #1;
    load_burst(0, 2); load_burst(1, 2);
    applyStimulus(100, 100);
    check_eq("s5 tie after reset", DW'(bus0.grant_o), DW'(2'b01));
    run_drain(100, 100, 40);

    $display("[TB] cap 3 with last on beat 3");
    do_reset();
    act = 2;
    load_burst(0, 3);
    run_drain(100, 100, 40);
    check_eq("s6 enq count", DW'(enq_cnt[2]), DW'(3));
    check_eq("s6 trunc count", DW'(trunc_cnt[2]), DW'(0));

    $display("[TB] randomized traffic");
    for (int r = 0; r < 9; r++) begin
      do_reset();
      act = r % NI;
      total = 0;
      for (int b = 0; b < 2; b++) begin
        int l0, l1;
        l0 = 1 + int'($urandom_range(8));
        l1 = 1 + int'($urandom_range(8));
        load_burst(0, l0); load_burst(1, l1);
        total += l0 + l1;
      end
      run_drain(60 + int'($urandom_range(40)), 50 + int'($urandom_range(50)), 600);
      check_eq($sformatf("rand%0d enq count", r), DW'(enq_cnt[act]), DW'(total));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
